feedthru_pipe: RTL and testbench

//  Parametrised multi-channel feed-through between hierarchy levels.

---
 rtl/feedthru_pipe.sv | 117 +++++++++++
 tb/tb_feedthru_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/feedthru_pipe.sv
`default_nettype none
// ============================================================================
// Module      : feedthru_pipe
// Description : Multi-channel valid/ready feed-through between hierarchy
//               levels. DEPTH=0 is a pure wire. DEPTH>0 inserts an elastic
//               register pipeline with bubble collapse and synchronous flush.
//               Optional macro FEEDTHRU_STALL_CNT_EN adds a saturating
//               stall counter (stall_cnt port, CNT_W parameter).
// Revision    : 1.0 - initial release
// ============================================================================
module feedthru_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2
`ifdef FEEDTHRU_STALL_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHANNELS-1:0] out_data
`ifdef FEEDTHRU_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_cnt
`endif
);

  // All channels travel together as one word; channel c sits at [c*WIDTH +: WIDTH].
  localparam int c_data_w = WIDTH * CHANNELS;

  if (DEPTH == 0) begin : g_wire
    // Pure combinational feed-through; flush has no effect and there is no state.
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
  end else begin : g_pipe
    logic [DEPTH-1:0]    r_valid;
    logic [c_data_w-1:0] r_data [DEPTH];
    logic [DEPTH:0]      w_load;
    logic [DEPTH-1:0]    w_src_valid;
    logic [c_data_w-1:0] w_src_data [DEPTH];
    logic                w_accept;

    // The last stage may load whenever the consumer takes the current word.
    assign w_load[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_load
      // A stage loads when it is empty (bubble) or its successor moves on.
      assign w_load[i] = ~r_valid[i] | w_load[i+1];
    end

    // Ready ripples combinationally from the consumer; no skid buffer.
    assign in_ready = w_load[0] & ~flush;
    assign w_accept = in_valid & in_ready;

    // Each stage is fed by its predecessor; stage 0 is fed by the producer.
    always_comb begin
      w_src_valid[0] = w_accept;
      w_src_data[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        w_src_valid[i] = r_valid[i-1];
        w_src_data[i]  = r_data[i-1];
      end
    end

    // Stage registers: flush drops every valid but leaves payloads untouched,
    // so the output payload keeps showing the last word the final stage held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_data[i] <= '0;
        end
      end else if (flush) begin
        r_valid <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_load[i]) begin
            r_valid[i] <= w_src_valid[i];
            if (w_src_valid[i]) begin
              r_data[i] <= w_src_data[i];
            end
          end
        end
      end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
  end

`ifdef FEEDTHRU_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Count cycles where a word waits on the consumer; saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_feedthru_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_feedthru_pipe
// Description : Directed bench for feedthru_pipe (DEPTH=2 and DEPTH=0
//               instances); stall counter checks when FEEDTHRU_STALL_CNT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feedthru_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef FEEDTHRU_STALL_CNT_EN
  logic [3:0]  stall_cnt;
`endif

  logic        z_flush;
  logic        z_in_valid;
  logic        z_in_ready;
  logic [15:0] z_in_data;
  logic        z_out_valid;
  logic        z_out_ready;
  logic [15:0] z_out_data;

  int n_pass;
  int n_total;

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
  } vec_t;

  vec_t vecs [21];

  feedthru_pipe #(
    .WIDTH(8), .CHANNELS(2), .DEPTH(2)
`ifdef FEEDTHRU_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef FEEDTHRU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  feedthru_pipe #(
    .WIDTH(8), .CHANNELS(2), .DEPTH(0)
`ifdef FEEDTHRU_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data)
`ifdef FEEDTHRU_STALL_CNT_EN
    , .stall_cnt()
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 16'hA55A;
    out_ready   = 1'b1;
    z_flush     = 1'b0;
    z_in_valid  = 1'b0;
    z_in_data   = 16'h0000;
    z_out_ready = 1'b0;

    //          iv    id        ordy  fl      ir    ov    od
    vecs[0]  = '{1'b1, 16'h1234, 1'b1, 1'b0,  1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b1, 16'h1234};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b0, 16'h1234};
    vecs[4]  = '{1'b1, 16'h0011, 1'b0, 1'b0,  1'b1, 1'b0, 16'h1234};
    vecs[5]  = '{1'b1, 16'h0022, 1'b0, 1'b0,  1'b1, 1'b0, 16'h1234};
    vecs[6]  = '{1'b1, 16'h0033, 1'b0, 1'b0,  1'b0, 1'b1, 16'h0011};
    vecs[7]  = '{1'b1, 16'h0033, 1'b1, 1'b0,  1'b1, 1'b1, 16'h0011};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b1, 16'h0022};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b1, 16'h0033};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0,  1'b1, 1'b0, 16'h0033};
    vecs[11] = '{1'b1, 16'h0044, 1'b0, 1'b0,  1'b1, 1'b0, 16'h0033};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0,  1'b1, 1'b0, 16'h0033};
    vecs[13] = '{1'b1, 16'h0055, 1'b0, 1'b0,  1'b1, 1'b1, 16'h0044};
    vecs[14] = '{1'b1, 16'h0066, 1'b0, 1'b1,  1'b0, 1'b1, 16'h0044};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b0, 16'h0044};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b0, 16'h0044};
    vecs[17] = '{1'b1, 16'h0077, 1'b1, 1'b0,  1'b1, 1'b0, 16'h0044};
    vecs[18] = '{1'b1, 16'h0088, 1'b1, 1'b0,  1'b1, 1'b0, 16'h0044};
    vecs[19] = '{1'b0, 16'h0000, 1'b1, 1'b1,  1'b0, 1'b1, 16'h0077};
    vecs[20] = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b0, 16'h0077};

    // Reset with a word offered: nothing may reach the output.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_out_data", out_data, 16'h0000);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", {15'd0, in_ready}, 16'h0001);

    // Cycle-by-cycle table: latency, backpressure, bubble collapse, flush.
    for (int r = 0; r < 21; r++) begin
      drive(vecs[r].iv, vecs[r].id, vecs[r].ordy, vecs[r].fl);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", r), {15'd0, in_ready}, {15'd0, vecs[r].e_ir});
      check($sformatf("vec%0d_out_valid", r), {15'd0, out_valid}, {15'd0, vecs[r].e_ov});
      check($sformatf("vec%0d_out_data", r), out_data, vecs[r].e_od);
    end

    // Streaming 0..9 at full rate: word k appears two cycles after it is pushed.
    for (int k = 0; k < 12; k++) begin
      drive((k < 10), 16'(k), 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("stream%0d_in_ready", k), {15'd0, in_ready}, 16'h0001);
      if (k >= 2) begin
        check($sformatf("stream%0d_out_valid", k), {15'd0, out_valid}, 16'h0001);
        check($sformatf("stream%0d_out_data", k), out_data, 16'(k - 2));
      end else begin
        check($sformatf("stream%0d_out_valid", k), {15'd0, out_valid}, 16'h0000);
      end
    end

    // Asynchronous reset mid-operation discards in-flight words at once.
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
    drive(1'b1, 16'hCAFE, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst_full_valid", {15'd0, out_valid}, 16'h0001);
    check("midrst_full_data", out_data, 16'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("midrst_out_data", out_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", {15'd0, in_ready}, 16'h0001);

    // DEPTH=0 instance: every output follows its input in the same cycle.
    for (int t = 0; t < 16; t++) begin
      @(posedge clk);
      #1;
      z_in_valid  = 1'($urandom_range(0, 1));
      z_out_ready = 1'($urandom_range(0, 1));
      z_flush     = 1'($urandom_range(0, 1));
      z_in_data   = 16'($urandom);
      #1;
      check($sformatf("wire%0d_data", t), z_out_data, z_in_data);
      check($sformatf("wire%0d_valid", t), {15'd0, z_out_valid}, {15'd0, z_in_valid});
      check($sformatf("wire%0d_ready", t), {15'd0, z_in_ready}, {15'd0, z_out_ready});
    end

`ifdef FEEDTHRU_STALL_CNT_EN
    // Stall counter saturates at 15 with CNT_W=4 and is cleared by flush.
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_after_flush", {12'd0, stall_cnt}, 16'h0000);
    drive(1'b1, 16'h00AA, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (22) @(posedge clk);
    @(negedge clk);
    check("stall_hold_valid", {15'd0, out_valid}, 16'h0001);
    check("stall_saturated", {12'd0, stall_cnt}, 16'h000F);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_flush_clear", {12'd0, stall_cnt}, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
